clint: RTL and testbench
========================

# clint

Core-local interrupt controller for the 16-bit CPU core. Detects synchronous traps (ECALL, EBREAK), MRET and asynchronous interrupts (external, optional timer). Runs the trap-entry and trap-return sequences against the CSR block, stalls the pipeline while doing so, and issues the redirect to the trap vector or return address. It is the producer side of the CSR block's `int_*` write port and the consumer of its `csr_*` outputs.

## Interface
- No parameters. Data and address width is 16 bits; instructions are 32 bits.
- `clk` in 1: core clock.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `inst_i` in 32: instruction currently in the ID/EX stage.
- `inst_addr_i` in 16: PC of `inst_i`.
- `jump_flag_i` in 1: EX redirect is active this cycle.
- `jump_addr_i` in 16: EX redirect target.
- `ex_hold_i` in 1: pipeline already stalled by another source; defers asynchronous interrupts only.
- `ext_irq_i` in 1: level external interrupt.
- `timer_irq_i` in 1: level timer interrupt; used only with `CLINT_TIMER_EN`.
- `csr_mtvec`, `csr_mepc`, `csr_mstatus` in 16 each: current CSR values.
- `global_int_en` in 1: mstatus.MIE.
- `int_we` out 3: CSR write strobes. Bit2 = mepc, bit1 = mcause, bit0 = mstatus.
- `int_mepc`, `int_mcause`, `int_mstatus` out 16 each: CSR write data.
- `hold_flag_o` out 1: stall the whole pipeline and suppress EX CSR writes.
- `int_assert_o` out 1: one-cycle redirect pulse.
- `int_addr_o` out 16: redirect target, valid while `int_assert_o` is high.

## Operation
- Instruction decode:
  - ECALL = 32'h00000073.
  - EBREAK = 32'h00100073.
  - MRET = 32'h30200073.
- States: IDLE, SAVE, MSTATUS, MRET_ST, JUMP.
- Triggers are evaluated only in IDLE. Priority, highest first:
  1. ECALL/EBREAK.
  2. MRET.
  3. External interrupt, when `ext_irq_i & global_int_en & ~ex_hold_i`.
  4. Timer interrupt, same qualification.
- Trap trigger in IDLE:
  - Latch mepc:
    - Sync trap: `inst_addr_i`.
    - Async interrupt: `jump_flag_i ? jump_addr_i : inst_addr_i`.
  - Latch mcause: ECALL 16'h000B, EBREAK 16'h0003, external 16'h800B, timer 16'h8007.
  - Go to SAVE.
- SAVE: `int_we`=3'b110, drive the latched mepc/mcause. Go to MSTATUS.
- MSTATUS: `int_we`=3'b001, `int_mstatus` = `csr_mstatus` with bit7 (MPIE) ← bit3, bit3 (MIE) ← 0. Latch target = `csr_mtvec`. Go to JUMP.
- MRET trigger: go to MRET_ST.
- MRET_ST: `int_we`=3'b001, `int_mstatus` = `csr_mstatus` with bit3 ← bit7, bit7 ← 1. Latch target = `csr_mepc`. Go to JUMP.
- JUMP: `int_assert_o`=1, `int_addr_o`=latched target. Go to IDLE.
- `hold_flag_o` = (state≠IDLE) | (trigger accepted in IDLE), combinational. Every other output is registered or decoded from state and latches.
- Interrupt lines are levels and are not latched. A request that drops before IDLE samples it is lost. A request still high after JUMP is not re-taken, because MIE is now 0.
- `int_we` is never nonzero while `hold_flag_o` is low, so EX CSR writes never coincide with CLINT writes.

## Timing
- Reset (`rst_n` low at a clk edge):
  - State → IDLE.
  - `int_we`=0; `int_mepc`, `int_mcause`, `int_mstatus`, `int_addr_o` = 16'h0000; `int_assert_o`=0.
  - Latches cleared. Applies mid-sequence too; no partial CSR write after reset.
- Trap, with detect cycle T0: T1 SAVE, T2 MSTATUS, T3 JUMP, T4 IDLE. `hold_flag_o` high for T0–T3 (4 cycles).
- MRET: T1 MRET_ST, T2 JUMP. `hold_flag_o` high for T0–T2 (3 cycles).
- Earliest next trigger is T4 (trap) or T3 (MRET).
- A simultaneous sync trap and interrupt takes the sync trap; the interrupt is re-evaluated after return only if it is still asserted and enabled.

## Configuration
- `CLINT_TIMER_EN` defined: `timer_irq_i` is serviced at priority 4 with mcause 16'h8007.
- Not defined: `timer_irq_i` is ignored, and no timer logic or cause encoding is generated.

## Test plan
- ECALL at PC 16'h0040, mtvec 16'h0100, mstatus 16'h0008 → T1 `int_we`=110, mepc 16'h0040, mcause 16'h000B; T2 `int_we`=001, mstatus 16'h0080; T3 `int_assert_o`=1, `int_addr_o`=16'h0100.
- MRET with mstatus 16'h0080, mepc 16'h0044 → T1 `int_mstatus`=16'h0088; T2 `int_addr_o`=16'h0044; hold high exactly 3 cycles.
- `ext_irq_i`=1 with `global_int_en`=0, or with `ex_hold_i`=1 → `hold_flag_o`, `int_we` and `int_assert_o` stay 0.
- `ext_irq_i`=1, MIE=1, `jump_flag_i`=1, `jump_addr_i`=16'h0200 → mepc 16'h0200, mcause 16'h800B. Same stimulus with ECALL in ID → mcause 16'h000B.
- Timer interrupt with MIE=1 → mcause 16'h8007 when `CLINT_TIMER_EN` is defined; no response when it is not.
- `rst_n` low during MSTATUS → next cycle IDLE, all outputs 0, no `int_we` pulse.

Source files
------------

// File: rtl/clint.sv
// Core-local interrupt controller: ECALL/EBREAK/MRET and external (optionally timer) interrupt sequencing.
// Latency: trap entry holds the pipeline 4 cycles, MRET 3 cycles. CLINT_TIMER_EN enables the timer source.
// Backpressure: ex_hold_i defers asynchronous interrupts only; hold_flag_o stalls the pipeline.
module clint (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [15:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [15:0] jump_addr_i,
    input  logic        ex_hold_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic [15:0] csr_mtvec,
    input  logic [15:0] csr_mepc,
    input  logic [15:0] csr_mstatus,
    input  logic        global_int_en,
    output logic [2:0]  int_we,
    output logic [15:0] int_mepc,
    output logic [15:0] int_mcause,
    output logic [15:0] int_mstatus,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [15:0] int_addr_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAVE    = 3'd1;
    localparam logic [2:0] S_MSTATUS = 3'd2;
    localparam logic [2:0] S_MRET    = 3'd3;
    localparam logic [2:0] S_JUMP    = 3'd4;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [15:0] CAUSE_ECALL  = 16'h000B;
    localparam logic [15:0] CAUSE_EBREAK = 16'h0003;
    localparam logic [15:0] CAUSE_EXT    = 16'h800B;

    logic [2:0]  state_q;
    logic [15:0] mepc_q;
    logic [15:0] cause_q;
    logic [15:0] target_q;

    logic        is_mret;
    logic        async_ok;
    logic        ext_take;
    logic        trap_take;
    logic [15:0] mepc_n;
    logic [15:0] cause_n;

    assign is_mret  = (inst_i == INST_MRET);
    assign async_ok = global_int_en & ~ex_hold_i;
    assign ext_take = ext_irq_i & async_ok;

`ifdef CLINT_TIMER_EN
    localparam logic [15:0] CAUSE_TIMER = 16'h8007;
    logic tim_take;
    assign tim_take = timer_irq_i & async_ok;
`else
    logic unused_timer;
    assign unused_timer = timer_irq_i;
`endif

    // Priority chain: sync traps, then MRET (blocks interrupts), then async sources.
    always_comb begin
        trap_take = 1'b0;
        mepc_n    = inst_addr_i;
        cause_n   = 16'h0000;
        if (inst_i == INST_ECALL) begin
            trap_take = 1'b1;
            cause_n   = CAUSE_ECALL;
        end else if (inst_i == INST_EBREAK) begin
            trap_take = 1'b1;
            cause_n   = CAUSE_EBREAK;
        end else if (is_mret) begin
            trap_take = 1'b0;
        end else if (ext_take) begin
            trap_take = 1'b1;
            mepc_n    = jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_n   = CAUSE_EXT;
        end
`ifdef CLINT_TIMER_EN
        else if (tim_take) begin
            trap_take = 1'b1;
            mepc_n    = jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_n   = CAUSE_TIMER;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mepc_q   <= 16'h0000;
            cause_q  <= 16'h0000;
            target_q <= 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trap_take) begin
                        mepc_q  <= mepc_n;
                        cause_q <= cause_n;
                        state_q <= S_SAVE;
                    end else if (is_mret) begin
                        state_q <= S_MRET;
                    end
                end
                S_SAVE:    state_q <= S_MSTATUS;
                S_MSTATUS: begin
                    target_q <= csr_mtvec;
                    state_q  <= S_JUMP;
                end
                S_MRET: begin
                    target_q <= csr_mepc;
                    state_q  <= S_JUMP;
                end
                S_JUMP:    state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    assign hold_flag_o = (state_q != S_IDLE) | trap_take | is_mret;

    always_comb begin
        int_we       = 3'b000;
        int_mepc     = 16'h0000;
        int_mcause   = 16'h0000;
        int_mstatus  = 16'h0000;
        int_assert_o = 1'b0;
        int_addr_o   = 16'h0000;
        case (state_q)
            S_SAVE: begin
                int_we     = 3'b110;
                int_mepc   = mepc_q;
                int_mcause = cause_q;
            end
            S_MSTATUS: begin
                int_we      = 3'b001;
                int_mstatus = {csr_mstatus[15:8], csr_mstatus[3], csr_mstatus[6:4],
                               1'b0, csr_mstatus[2:0]};
            end
            S_MRET: begin
                int_we      = 3'b001;
                int_mstatus = {csr_mstatus[15:8], 1'b1, csr_mstatus[6:4],
                               csr_mstatus[7], csr_mstatus[2:0]};
            end
            S_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clint.sv
// Randomized bench for clint against a cycle-schedule reference model.
module tb_clint;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [15:0] inst_addr_i;
    logic        jump_flag_i;
    logic [15:0] jump_addr_i;
    logic        ex_hold_i;
    logic        ext_irq_i;
    logic        timer_irq_i;
    logic [15:0] csr_mtvec;
    logic [15:0] csr_mepc;
    logic [15:0] csr_mstatus;
    logic        global_int_en;
    logic [2:0]  int_we;
    logic [15:0] int_mepc;
    logic [15:0] int_mcause;
    logic [15:0] int_mstatus;
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [15:0] int_addr_o;

    always #5 clk = ~clk;

    clint dut (
        .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .ex_hold_i(ex_hold_i),
        .ext_irq_i(ext_irq_i), .timer_irq_i(timer_irq_i), .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus), .global_int_en(global_int_en),
        .int_we(int_we), .int_mepc(int_mepc), .int_mcause(int_mcause),
        .int_mstatus(int_mstatus), .hold_flag_o(hold_flag_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    // Scheduled future cycles of a sequence: 1=save, 2=mstatus entry, 3=mret mstatus, 4=jump.
    typedef struct {
        int          kind;
        logic [15:0] mepc;
        logic [15:0] mcause;
    } ent_t;

    ent_t        sched[$];
    logic [15:0] m_target;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void push(input int kind, input logic [15:0] mepc, input logic [15:0] cause);
        ent_t t;
        t.kind   = kind;
        t.mepc   = mepc;
        t.mcause = cause;
        sched.push_back(t);
    endfunction

    function automatic void push_trap(input logic [15:0] mepc, input logic [15:0] cause);
        push(1, mepc, cause);
        push(2, 16'h0, 16'h0);
        push(4, 16'h0, 16'h0);
    endfunction

    // Called with inputs already applied; checks this cycle, then advances one clock.
    task automatic step();
        logic [15:0] e_we, e_mepc, e_cause, e_mst, e_addr, e_as, e_hold;
        logic        async_ok;
        logic [15:0] irq_pc;
        ent_t        e;
        #1;
        e_we = 0; e_mepc = 0; e_cause = 0; e_mst = 0; e_addr = 0; e_as = 0; e_hold = 0;
        async_ok = global_int_en && !ex_hold_i;
        irq_pc   = jump_flag_i ? jump_addr_i : inst_addr_i;
        if (sched.size() > 0) begin
            e = sched.pop_front();
            e_hold = 1;
            case (e.kind)
                1: begin e_we = 6; e_mepc = e.mepc; e_cause = e.mcause; end
                2: begin
                    e_we = 1;
                    e_mst = (csr_mstatus & 16'hFF77) | (csr_mstatus[3] ? 16'h0080 : 16'h0000);
                    m_target = csr_mtvec;
                end
                3: begin
                    e_we = 1;
                    e_mst = (csr_mstatus & 16'hFFF7) | 16'h0080 | (csr_mstatus[7] ? 16'h0008 : 16'h0000);
                    m_target = csr_mepc;
                end
                default: begin e_as = 1; e_addr = m_target; end
            endcase
        end else begin
            e_hold = 1;
            if (inst_i == ECALL) push_trap(inst_addr_i, 16'h000B);
            else if (inst_i == EBREAK) push_trap(inst_addr_i, 16'h0003);
            else if (inst_i == MRET) begin push(3, 16'h0, 16'h0); push(4, 16'h0, 16'h0); end
            else if (ext_irq_i && async_ok) push_trap(irq_pc, 16'h800B);
`ifdef CLINT_TIMER_EN
            else if (timer_irq_i && async_ok) push_trap(irq_pc, 16'h8007);
`endif
            else e_hold = 0;
        end
        check("hold", 16'(hold_flag_o), e_hold);
        check("we", 16'(int_we), e_we);
        check("mepc", int_mepc, e_mepc);
        check("mcause", int_mcause, e_cause);
        check("mstatus", int_mstatus, e_mst);
        check("assert", 16'(int_assert_o), e_as);
        check("addr", int_addr_o, e_addr);
        @(posedge clk);
        if (!rst_n) begin
            sched.delete();
            m_target = 16'h0;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        inst_i = NOP; ext_irq_i = 0; timer_irq_i = 0; jump_flag_i = 0; ex_hold_i = 0;
    endtask

    initial begin
        rst_n = 0; quiet(); inst_addr_i = 16'h0; jump_addr_i = 16'h0;
        csr_mtvec = 16'h0; csr_mepc = 16'h0; csr_mstatus = 16'h0; global_int_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        step();

        // ECALL entry sequence
        inst_i = ECALL; inst_addr_i = 16'h0040; csr_mtvec = 16'h0100; csr_mstatus = 16'h0008;
        global_int_en = 1;
        step(); quiet();
        check("ecall_t1_we", 16'(int_we), 16'h0006);
        check("ecall_t1_mepc", int_mepc, 16'h0040);
        check("ecall_t1_cause", int_mcause, 16'h000B);
        step();
        check("ecall_t2_mst", int_mstatus, 16'h0080);
        step();
        check("ecall_t3_addr", int_addr_o, 16'h0100);
        step(); step();

        // MRET return sequence
        inst_i = MRET; csr_mstatus = 16'h0080; csr_mepc = 16'h0044;
        step(); quiet();
        check("mret_t1_mst", int_mstatus, 16'h0088);
        step();
        check("mret_t2_addr", int_addr_o, 16'h0044);
        step();
        check("mret_t3_hold", 16'(hold_flag_o), 16'h0000);
        step();

        // Disabled or held interrupts are ignored
        ext_irq_i = 1; global_int_en = 0;
        repeat (3) step();
        global_int_en = 1; ex_hold_i = 1;
        repeat (3) step();
        ex_hold_i = 0;

        // External interrupt with an active EX redirect
        jump_flag_i = 1; jump_addr_i = 16'h0200; inst_addr_i = 16'h0050;
        step(); quiet();
        check("ext_mepc", int_mepc, 16'h0200);
        check("ext_cause", int_mcause, 16'h800B);
        repeat (3) step();

        // Sync trap wins over a simultaneous interrupt
        ext_irq_i = 1; jump_flag_i = 1; inst_i = ECALL; inst_addr_i = 16'h0060;
        step(); quiet();
        check("prio_cause", int_mcause, 16'h000B);
        check("prio_mepc", int_mepc, 16'h0060);
        repeat (3) step();

        // Timer source (serviced only when enabled at build time)
        timer_irq_i = 1; global_int_en = 1;
        step(); timer_irq_i = 0;
        repeat (4) step();

        // Reset during MSTATUS aborts the sequence
        inst_i = EBREAK; inst_addr_i = 16'h0070;
        step(); quiet();
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        check("rst_we", 16'(int_we), 16'h0000);
        check("rst_hold", 16'(hold_flag_o), 16'h0000);
        check("rst_assert", 16'(int_assert_o), 16'h0000);
        repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0: inst_i = ECALL;
                1: inst_i = EBREAK;
                2: inst_i = MRET;
                default: inst_i = $urandom;
            endcase
            inst_addr_i   = 16'($urandom) & 16'hFFFE;
            jump_flag_i   = ($urandom_range(0, 2) == 0);
            jump_addr_i   = 16'($urandom) & 16'hFFFE;
            ex_hold_i     = ($urandom_range(0, 3) == 0);
            ext_irq_i     = ($urandom_range(0, 2) == 0);
            timer_irq_i   = ($urandom_range(0, 2) == 0);
            global_int_en = ($urandom_range(0, 1) == 0);
            csr_mtvec     = 16'($urandom);
            csr_mepc      = 16'($urandom);
            csr_mstatus   = 16'($urandom);
            rst_n         = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
